// File: rtl/aes_mix_addkey.sv
// aes_mix_addkey: AES round tail that applies AddRoundKey around a column-serial MixColumns engine.
// Optional feature: define AES_MIXREQ_TIMEOUT_EN to abort a transaction that waits TIMEOUT cycles with no mc_ready_i.
module aes_mix_addkey
`ifdef AES_MIXREQ_TIMEOUT_EN
   #(parameter logic [3:0] TIMEOUT = 4'd8)
`endif
   (
   input  logic         clk,
   input  logic         reset,
   input  logic         go_i,
   input  logic         decrypt_i,
   input  logic         last_round_i,
   input  logic [127:0] state_i,
   input  logic [127:0] key_i,
   output logic         mc_start_o,
   output logic         mc_decrypt_o,
   output logic [127:0] mc_data_o,
   input  logic         mc_ready_i,
   input  logic [127:0] mc_data_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [127:0] data_o,
   output logic         err_o
   );
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
   state_t state, state_nx;
   logic [127:0] w, k_q;
   logic dec_q, accept, finish, expire;
   assign accept = (state == IDLE) && go_i;
   assign finish = (state == WAIT) && mc_ready_i;
   assign mc_data_o = w;
   assign mc_decrypt_o = dec_q;
`ifdef AES_MIXREQ_TIMEOUT_EN
   logic [3:0] cnt;
   assign expire = (state == WAIT) && !mc_ready_i && (cnt == TIMEOUT - 4'd1);
   // count WAIT cycles spent without an engine response; zero outside WAIT
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (state != WAIT) cnt <= '0;
      else if (!mc_ready_i) cnt <= cnt + 4'd1;
   // one-cycle error pulse when the wait budget runs out
   always_ff @(posedge clk or posedge reset)
      if (reset) err_o <= 1'b0;
      else err_o <= expire;
`else
   assign expire = 1'b0;
   assign err_o = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   // next state: a ready arriving on the expiry cycle still counts as a completion
   always_comb
      state_nx = (state == IDLE) ? ((go_i && !last_round_i) ? REQ : IDLE) :
                 (state == REQ)  ? WAIT :
                 (finish || expire) ? IDLE : WAIT;
   // outputs decoded from the state register
   always_comb begin
      busy_o = (state != IDLE);
      mc_start_o = (state == REQ);
   end
   // operand/key capture on accept, result and done pulse on completion
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         w <= '0;
         k_q <= '0;
         dec_q <= 1'b0;
         data_o <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= (accept && last_round_i) || finish;
         if (accept && !last_round_i) begin
            w <= decrypt_i ? state_i ^ key_i : state_i;
            k_q <= key_i;
            dec_q <= decrypt_i;
         end
         if (accept && last_round_i) data_o <= state_i ^ key_i;
         else if (finish) data_o <= dec_q ? mc_data_i : mc_data_i ^ k_q;
      end
endmodule

// File: tb/tb_aes_mix_addkey.sv
// tb_aes_mix_addkey: randomized bench with a transaction-level reference model and a behavioural MixColumns engine.
module tb_aes_mix_addkey;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, go_i, decrypt_i, last_round_i, mc_ready_i;
   logic [127:0] state_i, key_i, mc_data_i;
   logic mc_start_o, mc_decrypt_o, busy_o, done_o, err_o;
   logic [127:0] mc_data_o, data_o;
`ifdef AES_MIXREQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO = 8;
   localparam logic [127:0] S1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] D1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] LS = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] LK = 128'h000102030405060708090a0b0c0d0e0f;

   aes_mix_addkey dut (
      .clk(clk), .reset(reset), .go_i(go_i), .decrypt_i(decrypt_i), .last_round_i(last_round_i),
      .state_i(state_i), .key_i(key_i), .mc_start_o(mc_start_o), .mc_decrypt_o(mc_decrypt_o),
      .mc_data_o(mc_data_o), .mc_ready_i(mc_ready_i), .mc_data_i(mc_data_i), .busy_o(busy_o),
      .done_o(done_o), .data_o(data_o), .err_o(err_o));

   int n_pass = 0, n_tot = 0;
   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // GF(2^8) arithmetic for the reference MixColumns / InvMixColumns
   function automatic logic [7:0] xt(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gm(logic [7:0] a, int m);
      logic [7:0] r = 8'h00, p = a;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) r ^= p;
         p = xt(p);
      end
      return r;
   endfunction
   function automatic logic [127:0] mix(logic [127:0] s, logic inv);
      int c [4];
      logic [127:0] o = '0;
      logic [7:0] acc;
      if (inv) c = '{14, 11, 13, 9};
      else c = '{2, 3, 1, 1};
      for (int col = 0; col < 4; col++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gm(s[127 - 32*col - 8*j -: 8], c[(j - r) & 3]);
            o[127 - 32*col - 8*r -: 8] = acc;
         end
      return o;
   endfunction

   // reference model: one outstanding transaction, phase counted in cycles since go
   bit m_busy = 0, e_done = 0, e_err = 0;
   int m_age = 0;
   logic m_dec = 1'b0;
   logic [127:0] m_op = '0, m_res = '0, e_data = '0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_age = 0; e_done = 0; e_err = 0; e_data = '0; m_dec = 1'b0; m_op = '0;
      end else begin
         e_done = 0;
         e_err = 0;
         if (m_busy) begin
            if (m_age >= 2 && mc_ready_i) begin
               m_busy = 0; e_done = 1; e_data = m_res;
            end else if (TO_EN && m_age == TO + 1) begin
               m_busy = 0; e_err = 1;
            end else m_age++;
         end else if (go_i) begin
            if (last_round_i) begin
               e_data = state_i ^ key_i; e_done = 1;
            end else begin
               m_busy = 1; m_age = 1; m_dec = decrypt_i;
               m_op = decrypt_i ? state_i ^ key_i : state_i;
               m_res = decrypt_i ? mix(state_i ^ key_i, 1'b1) : mix(state_i, 1'b0) ^ key_i;
            end
         end
      end
   end

   // compare every output against the model each cycle
   always @(negedge clk) begin
      chk("busy", 128'(busy_o), 128'(m_busy));
      chk("mc_start", 128'(mc_start_o), 128'(m_busy && m_age == 1));
      chk("done", 128'(done_o), 128'(e_done));
      chk("err", 128'(err_o), 128'(e_err));
      chk("data", data_o, e_data);
      chk("mc_data", mc_data_o, m_op);
      chk("mc_decrypt", 128'(mc_decrypt_o), 128'(m_dec));
   end

   // behavioural MixColumns engine: ready eng_lat cycles after start (0 = never)
   int eng_cnt = 0, eng_lat = 4;
   bit eng_rand = 0, eng_spur = 0;
   function automatic int pick_lat();
      int l [10] = '{1, 2, 3, 4, 5, 6, 8, 9, 12, 0};
      return TO_EN ? l[$urandom_range(9)] : int'($urandom_range(6, 1));
   endfunction
   initial begin
      mc_ready_i = 1'b0;
      mc_data_i = '0;
      forever begin
         @(posedge clk);
         #1;
         mc_ready_i = 1'b0;
         if (reset) eng_cnt = 0;
         else begin
            if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  mc_ready_i = 1'b1;
                  mc_data_i = mix(mc_data_o, mc_decrypt_o);
               end
            end else if (eng_spur && !busy_o && $urandom_range(3) == 0) begin
               mc_ready_i = 1'b1;
               mc_data_i = {4{$urandom}};
            end
            if (mc_start_o) eng_cnt = eng_rand ? pick_lat() : eng_lat;
         end
      end
   end

   int starts_seen;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic go(input logic [127:0] s, input logic [127:0] k, input logic dec, input logic last);
      go_i = 1'b1; state_i = s; key_i = k; decrypt_i = dec; last_round_i = last;
      tick;
      go_i = 1'b0; state_i = {4{$urandom}}; key_i = {4{$urandom}};
      decrypt_i = 1'($urandom_range(1)); last_round_i = 1'($urandom_range(1));
   endtask
   task automatic wait_evt(output int n);
      n = 0;
      starts_seen = 0;
      forever begin
         @(negedge clk);
         starts_seen += int'(mc_start_o);
         if (done_o || err_o) return;
         n++;
         if (n > 60) begin
            n_tot++;
            $display("FAIL wait_evt: no done_o/err_o within 60 cycles");
            return;
         end
         tick;
      end
   endtask

   initial begin
      int n, d;
      logic [127:0] prev;
      reset = 1'b1; go_i = 1'b0; decrypt_i = 1'b0; last_round_i = 1'b0; state_i = '0; key_i = '0;
      repeat (2) tick;
      @(negedge clk);
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_data", data_o, 128'(0));
      chk("rst_mc_data", mc_data_o, 128'(0));
      tick;
      reset = 1'b0;
      tick;
      go(S1, '0, 1'b0, 1'b0);
      wait_evt(n);
      chk("enc_latency", 128'(n + 1), 128'(6));
      chk("enc_starts", 128'(starts_seen), 128'(1));
      chk("enc_data", data_o, D1);
      tick;
      go(D1, '0, 1'b1, 1'b0);
      wait_evt(n);
      chk("dec_latency", 128'(n + 1), 128'(6));
      chk("dec_data", data_o, S1);
      tick;
      go(S1, ONES, 1'b0, 1'b0);
      wait_evt(n);
      chk("enc_key_data", data_o, 128'h71b25e43_6023a762_fefefefe_39393939);
      tick;
      go(LS, LK, 1'b0, 1'b1);
      wait_evt(n);
      chk("last_latency", 128'(n + 1), 128'(1));
      chk("last_starts", 128'(starts_seen), 128'(0));
      chk("last_data", data_o, 128'h00102030405060708090a0b0c0d0e0f0);
      tick;
      go(S1, '0, 1'b0, 1'b0);
      tick;
      go_i = 1'b1; state_i = LS; key_i = LK; last_round_i = 1'b1;
      tick;
      go_i = 1'b0;
      tick;
      go_i = 1'b1;
      tick;
      go_i = 1'b0;
      tick;
      go_i = 1'b1; state_i = D1; key_i = '0; decrypt_i = 1'b1; last_round_i = 1'b0;
      @(negedge clk);
      chk("busy_go_done", 128'(done_o), 128'(1));
      chk("busy_go_data", data_o, D1);
      tick;
      go_i = 1'b0;
      wait_evt(n);
      chk("b2b_latency", 128'(n), 128'(5));
      chk("b2b_data", data_o, S1);
      if (TO_EN) begin
         tick;
         eng_lat = 0;
         prev = data_o;
         go(S1, ONES, 1'b0, 1'b0);
         wait_evt(n);
         chk("to_latency", 128'(n + 1), 128'(10));
         chk("to_err", 128'(err_o), 128'(1));
         chk("to_no_done", 128'(done_o), 128'(0));
         chk("to_data_kept", data_o, prev);
         tick;
         eng_lat = 8;
         go(S1, '0, 1'b0, 1'b0);
         wait_evt(n);
         chk("edge_latency", 128'(n + 1), 128'(10));
         chk("edge_done", 128'(done_o), 128'(1));
         chk("edge_no_err", 128'(err_o), 128'(0));
         chk("edge_data", data_o, D1);
         eng_lat = 4;
      end
      tick;
      go(S1, ONES, 1'b0, 1'b0);
      tick;
      tick;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 128'(busy_o), 128'(0));
      chk("mid_rst_start", 128'(mc_start_o), 128'(0));
      chk("mid_rst_done", 128'(done_o), 128'(0));
      chk("mid_rst_data", data_o, 128'(0));
      chk("mid_rst_mc_data", mc_data_o, 128'(0));
      chk("mid_rst_mc_dec", 128'(mc_decrypt_o), 128'(0));
      chk("mid_rst_err", 128'(err_o), 128'(0));
      tick;
      tick;
      reset = 1'b0;
      d = 0;
      repeat (10) begin
         @(negedge clk);
         d += int'(done_o);
         tick;
      end
      chk("rst_no_done", 128'(d), 128'(0));
      eng_rand = 1;
      eng_spur = 1;
      repeat (2000) begin
         tick;
         go_i = ($urandom_range(2) == 0);
         state_i = {4{$urandom}};
         key_i = {4{$urandom}};
         decrypt_i = 1'($urandom_range(1));
         last_round_i = ($urandom_range(3) == 0);
      end
      tick;
      go_i = 1'b0;
      repeat (20) tick;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
